simple_fifo: RTL and testbench

SIMPLE_FIFO -- requirements
Module: simple_fifo

---
 rtl/simple_fifo_pkg.sv | 13 +
 rtl/simple_fifo_wrapping_counter.sv | 39 +++
 rtl/simple_fifo.sv | 111 +++++++++++
 tb/tb_simple_fifo.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_fifo_pkg.sv
// simple_fifo_pkg: sizing helper shared by the FIFO and its pointer counters.
`default_nettype none

package simple_fifo_pkg;

   // Index width for a range of n values; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/simple_fifo_wrapping_counter.sv
// wrapping_counter: modulo-RANGE up-counter that wraps from RANGE-1 to 0 explicitly.
`default_nettype none

module wrapping_counter
   import simple_fifo_pkg::*;
#(
   parameter int RANGE = 4,
   localparam int CW = idx_width(RANGE)
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          increment,
   output logic [CW-1:0] count
);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Explicit wrap keeps non-power-of-two ranges correct.
   always_comb begin
      count_d = count_q;
      if (increment) begin
         count_d = (count_q == CW'(RANGE - 1)) ? '0 : count_q + CW'(1);
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/simple_fifo.sv
// simple_fifo: first-word-fall-through synchronous FIFO, any DEPTH >= 2.
// Define SIMPLE_FIFO_ERROR_FLAGS_EN to add overflow/underflow pulse outputs.
`default_nettype none

module simple_fifo
   import simple_fifo_pkg::*;
#(
   parameter int WIDTH                  = 8,
   parameter int DEPTH                  = 4,
   parameter int ALMOST_FULL_THRESHOLD  = DEPTH - 1,
   parameter int ALMOST_EMPTY_THRESHOLD = 1,
   localparam int LVL_W                 = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             write_enable,
   input  logic [WIDTH-1:0] write_data,
   output logic             full,
   input  logic             read_enable,
   output logic [WIDTH-1:0] read_data,
   output logic             empty,
   output logic [LVL_W-1:0] level,
   output logic             almost_full,
   output logic             almost_empty
`ifdef SIMPLE_FIFO_ERROR_FLAGS_EN
   ,
   output logic             overflow,
   output logic             underflow
`endif
);

   localparam int PTR_W = idx_width(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [LVL_W-1:0] level_q;
   logic [LVL_W-1:0] level_d;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push;
   logic             pop;

   // Acceptance is gated only by the flags, so a full FIFO drops a write even
   // when a read frees a slot in the same cycle, and an empty one never bypasses.
   assign push = write_enable && !full;
   assign pop  = read_enable && !empty;

   wrapping_counter #(.RANGE(DEPTH)) u_wr_ptr (
      .clock     (clock),
      .resetn    (resetn),
      .increment (push),
      .count     (wr_ptr)
   );

   wrapping_counter #(.RANGE(DEPTH)) u_rd_ptr (
      .clock     (clock),
      .resetn    (resetn),
      .increment (pop),
      .count     (rd_ptr)
   );

   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr] <= write_data;
      end
   end

   always_comb begin
      level_d = level_q;
      if (push && !pop) begin
         level_d = level_q + LVL_W'(1);
      end else if (pop && !push) begin
         level_d = level_q - LVL_W'(1);
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         level_q <= '0;
      end else begin
         level_q <= level_d;
      end
   end

   assign level        = level_q;
   assign full         = (level_q == LVL_W'(DEPTH));
   assign empty        = (level_q == '0);
   assign almost_full  = (int'(level_q) >= ALMOST_FULL_THRESHOLD);
   assign almost_empty = (int'(level_q) <= ALMOST_EMPTY_THRESHOLD);
   assign read_data    = mem_q[rd_ptr];

`ifdef SIMPLE_FIFO_ERROR_FLAGS_EN
   logic overflow_q;
   logic underflow_q;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= write_enable && full;
         underflow_q <= read_enable && empty;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_simple_fifo.sv
// tb_simple_fifo: directed and random checks of simple_fifo (DEPTH 4 and 3) against a queue model.
`default_nettype none

module tb_simple_fifo;

   logic       clock = 1'b0;
   logic       resetn;
   logic       we4, re4, we3, re3;
   logic [7:0] wd4, wd3;
   logic       full4, empty4, af4, ae4;
   logic       full3, empty3, af3, ae3;
   logic [7:0] rd4, rd3;
   logic [2:0] lvl4;
   logic [1:0] lvl3;
`ifdef SIMPLE_FIFO_ERROR_FLAGS_EN
   logic       ovf4, udf4, ovf3, udf3;
`endif

   int         n_assert = 0;
   int         n_fail   = 0;
   logic [7:0] q4[$];
   logic [7:0] q3[$];
   logic       exp_ovf4, exp_udf4, exp_ovf3, exp_udf3;

   always #5 clock = ~clock;

   simple_fifo #(.WIDTH(8), .DEPTH(4)) dut4 (
      .clock        (clock),
      .resetn       (resetn),
      .write_enable (we4),
      .write_data   (wd4),
      .full         (full4),
      .read_enable  (re4),
      .read_data    (rd4),
      .empty        (empty4),
      .level        (lvl4),
      .almost_full  (af4),
      .almost_empty (ae4)
`ifdef SIMPLE_FIFO_ERROR_FLAGS_EN
      ,
      .overflow     (ovf4),
      .underflow    (udf4)
`endif
   );

   simple_fifo #(.WIDTH(8), .DEPTH(3)) dut3 (
      .clock        (clock),
      .resetn       (resetn),
      .write_enable (we3),
      .write_data   (wd3),
      .full         (full3),
      .read_enable  (re3),
      .read_data    (rd3),
      .empty        (empty3),
      .level        (lvl3),
      .almost_full  (af3),
      .almost_empty (ae3)
`ifdef SIMPLE_FIFO_ERROR_FLAGS_EN
      ,
      .overflow     (ovf3),
      .underflow    (udf3)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] head4();
      return (q4.size() > 0) ? q4[0] : 8'h00;
   endfunction

   function automatic logic [7:0] head3();
      return (q3.size() > 0) ? q3[0] : 8'h00;
   endfunction

   // Flags follow from the entry count alone; thresholds are the defaults DEPTH-1 and 1.
   task automatic check_fifo(input string tag, input int depth, input int size,
                             input logic [7:0] head, input logic [31:0] lvl,
                             input logic emp, input logic fl, input logic af,
                             input logic ae, input logic [7:0] rd);
      check({tag, ".level"},        lvl,      32'(size));
      check({tag, ".empty"},        32'(emp), 32'(size == 0));
      check({tag, ".full"},         32'(fl),  32'(size == depth));
      check({tag, ".almost_full"},  32'(af),  32'(size >= depth - 1));
      check({tag, ".almost_empty"}, 32'(ae),  32'(size <= 1));
      if (size > 0) check({tag, ".read_data"}, 32'(rd), 32'(head));
   endtask

   task automatic tick();
      int s4;
      int s3;
      s4 = q4.size();
      s3 = q3.size();
      exp_ovf4 = we4 && (s4 == 4);
      exp_udf4 = re4 && (s4 == 0);
      exp_ovf3 = we3 && (s3 == 3);
      exp_udf3 = re3 && (s3 == 0);
      @(posedge clock);
      #1;
      if (re4 && s4 > 0) void'(q4.pop_front());
      if (we4 && s4 < 4) q4.push_back(wd4);
      if (re3 && s3 > 0) void'(q3.pop_front());
      if (we3 && s3 < 3) q3.push_back(wd3);
      check_fifo("f4", 4, q4.size(), head4(), 32'(lvl4), empty4, full4, af4, ae4, rd4);
      check_fifo("f3", 3, q3.size(), head3(), 32'(lvl3), empty3, full3, af3, ae3, rd3);
`ifdef SIMPLE_FIFO_ERROR_FLAGS_EN
      check("f4.overflow",  32'(ovf4), 32'(exp_ovf4));
      check("f4.underflow", 32'(udf4), 32'(exp_udf4));
      check("f3.overflow",  32'(ovf3), 32'(exp_ovf3));
      check("f3.underflow", 32'(udf3), 32'(exp_udf3));
`endif
   endtask

   initial begin
      int xfers;
      int cycles;
      int guard;

      resetn = 1'b0;
      we4 = 1'b0; re4 = 1'b0; wd4 = 8'h00;
      we3 = 1'b0; re3 = 1'b0; wd3 = 8'h00;

      // Reset state
      #1;
      check("rst.level",        32'(lvl4),   32'd0);
      check("rst.empty",        32'(empty4), 32'd1);
      check("rst.full",         32'(full4),  32'd0);
      check("rst.almost_empty", 32'(ae4),    32'd1);
      check("rst.almost_full",  32'(af4),    32'd0);
      check_fifo("rst3", 3, 0, 8'h00, 32'(lvl3), empty3, full3, af3, ae3, rd3);
      #11;
      resetn = 1'b1;

      // Single write becomes visible one cycle later
      we4 = 1'b1; wd4 = 8'hAA;
      tick();
      check("aa.empty", 32'(empty4), 32'd0);
      check("aa.full",  32'(full4),  32'd0);
      check("aa.level", 32'(lvl4),   32'd1);
      check("aa.data",  32'(rd4),    32'hAA);
      we4 = 1'b0; re4 = 1'b1;
      tick();
      re4 = 1'b0;

      // Fill to full, then a write with a concurrent read is dropped
      for (int i = 1; i <= 4; i++) begin
         we4 = 1'b1; wd4 = 8'(i);
         tick();
         if (i == 3) check("fill.af_at3", 32'(af4), 32'd1);
      end
      check("fill.full",  32'(full4), 32'd1);
      check("fill.level", 32'(lvl4),  32'd4);
      check("ovf.pre_head", 32'(rd4), 32'h01);
      we4 = 1'b1; wd4 = 8'h05; re4 = 1'b1;
      tick();
      check("ovf.level", 32'(lvl4), 32'd3);
      check("ovf.head",  32'(rd4),  32'h02);
      we4 = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      re4 = 1'b0;

      // Refill, then drain in order and read once more while empty
      for (int i = 1; i <= 4; i++) begin
         we4 = 1'b1; wd4 = 8'(i);
         tick();
      end
      we4 = 1'b0; re4 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("drain.data", 32'(rd4), 32'(i + 1));
         tick();
         if (i == 2) check("drain.ae_at1", 32'(ae4), 32'd1);
      end
      check("drain.empty", 32'(empty4), 32'd1);
      check("drain.level", 32'(lvl4),   32'd0);
      tick();
      check("udf.level", 32'(lvl4), 32'd0);

      // Read on empty with a write: the write lands, no bypass
      we4 = 1'b1; re4 = 1'b1; wd4 = 8'h77;
      tick();
      check("ebyp.level", 32'(lvl4), 32'd1);
      check("ebyp.data",  32'(rd4),  32'h77);
      we4 = 1'b0;
      tick();
      re4 = 1'b0;

      // DEPTH=3: sustained simultaneous push/pop at level 1 wraps the pointers
      we3 = 1'b1; wd3 = 8'h10;
      tick();
      re3 = 1'b1;
      for (int i = 0; i < 100; i++) begin
         wd3 = 8'(8'h11 + i);
         check("d3.head", 32'(rd3), 32'(8'(8'h10 + i)));
         tick();
         check("d3.level", 32'(lvl3), 32'd1);
      end
      we3 = 1'b0;
      tick();
      re3 = 1'b0;

      // Random push/pop against the queue model
      xfers  = 0;
      cycles = 0;
      while (xfers < 1000 && cycles < 10000) begin
         we4 = 1'($urandom_range(0, 1));
         re4 = 1'($urandom_range(0, 1));
         wd4 = 8'($urandom);
         if (we4 && q4.size() < 4) xfers++;
         if (re4 && q4.size() > 0) xfers++;
         tick();
         cycles++;
      end
      check("rand.completed", 32'(xfers >= 1000), 32'd1);
      we4 = 1'b0; re4 = 1'b1;
      guard = 0;
      while (q4.size() > 0 && guard < 20) begin
         tick();
         guard++;
      end
      re4 = 1'b0;
      check("rand.final_empty", 32'(empty4), 32'd1);

      // Asynchronous reset at level 2 discards contents
      we4 = 1'b1; wd4 = 8'hA1;
      tick();
      wd4 = 8'hA2;
      tick();
      we4 = 1'b0;
      check("mrst.pre_level", 32'(lvl4), 32'd2);
      #2;
      resetn = 1'b0;
      #1;
      check("mrst.level", 32'(lvl4),   32'd0);
      check("mrst.empty", 32'(empty4), 32'd1);
`ifdef SIMPLE_FIFO_ERROR_FLAGS_EN
      check("mrst.overflow",  32'(ovf4), 32'd0);
      check("mrst.underflow", 32'(udf4), 32'd0);
`endif
      q4.delete();
      q3.delete();
      @(negedge clock);
      resetn = 1'b1;
      we4 = 1'b1; wd4 = 8'h5C;
      tick();
      check("mrst.first_data", 32'(rd4),  32'h5C);
      check("mrst.first_lvl",  32'(lvl4), 32'd1);
      we4 = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
